// File: rtl/dac_spi_writer.sv
// dac_spi_writer: saturates a signed control word to DAC width and shifts it MSB-first, offset binary, to a serial DAC
module dac_spi_writer #(
  parameter int IN_WIDTH   = 24,
  parameter int DATA_WIDTH = 16,
  parameter int SCLK_HALF  = 2,
  parameter int CS_GAP     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [IN_WIDTH-1:0] data_in,
  input  logic                       data_valid,
  output logic                       data_ready,
  output logic                       dac_sclk,
  output logic                       dac_cs_n,
  output logic                       dac_sdi,
  output logic                       frame_done,
  output logic                       sat_flag
);
  localparam int CNT_MAX = SCLK_HALF > CS_GAP ? SCLK_HALF : CS_GAP;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] SH_LD = CW'(SCLK_HALF - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(CS_GAP - 1);
  localparam logic signed [IN_WIDTH-1:0] MAX_V = {{(IN_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH-1:0] MIN_V = ~MAX_V;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_idx, bit_n;
  logic [DATA_WIDTH-1:0] sr, sr_n;
  logic sclk_n, cs_n_n, sdi_n, done_n, sat_n;
  logic hi, lo, accept, cnt_zero;
  assign data_ready = state == IDLE && !reset;
  assign accept = data_valid && data_ready;
  assign hi = data_in > MAX_V;
  assign lo = data_in < MIN_V;
  assign cnt_zero = cnt == '0;
  // state, counters, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      sr         <= '0;
      dac_sclk   <= 1'b0;
      dac_cs_n   <= 1'b1;
      dac_sdi    <= 1'b0;
      frame_done <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      sr         <= sr_n;
      dac_sclk   <= sclk_n;
      dac_cs_n   <= cs_n_n;
      dac_sdi    <= sdi_n;
      frame_done <= done_n;
      sat_flag   <= sat_n;
    end
  end
  // phase sequencing: each phase lasts cnt+1 cycles; sclk toggles at phase ends, data advances on its falling edge
  always_comb begin
    state_n = state;
    cnt_n   = cnt_zero ? cnt : cnt - 1'b1;
    bit_n   = bit_idx;
    sr_n    = sr;
    sclk_n  = dac_sclk;
    sat_n   = sat_flag;
    case (state)
      IDLE: if (accept) begin
        state_n = SETUP;
        cnt_n   = SH_LD;
        sr_n    = hi ? '1 : lo ? '0 : {~data_in[DATA_WIDTH-1], data_in[DATA_WIDTH-2:0]};
        sat_n   = hi || lo;
      end
      SETUP: if (cnt_zero) begin
        state_n = SHIFT;
        cnt_n   = SH_LD;
        sclk_n  = 1'b1;
        bit_n   = BW'(DATA_WIDTH - 1);
      end
      SHIFT: if (cnt_zero) begin
        cnt_n  = SH_LD;
        sclk_n = !dac_sclk;
        if (dac_sclk) begin
          if (bit_idx == '0) state_n = HOLD;
          else begin
            sr_n  = sr << 1;
            bit_n = bit_idx - 1'b1;
          end
        end
      end
      HOLD: if (cnt_zero) begin
        state_n = GAP;
        cnt_n   = GAP_LD;
      end
      GAP: if (cnt_zero) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // output values for the coming cycle, derived from the next state
  always_comb begin
    cs_n_n = state_n == IDLE || state_n == GAP;
    sdi_n  = !cs_n_n && sr_n[DATA_WIDTH-1];
    done_n = state == HOLD && state_n == GAP;
  end
endmodule

// File: doc/dac_spi_writer.md
Name: dac_spi_writer

Overview:
- Output-side counterpart of the ADC/error path in the digital PI loop.
- Accepts one signed control word per handshake from the PI accumulator and saturates it to DAC width.
- Converts the result to offset binary and shifts it MSB-first to a serial SPI-style DAC, framed by chip-select.
- Sits between the PI controller output and the DAC pins.

Parameters:
- IN_WIDTH, 24: width of signed input word from the PI stage; must be >= DATA_WIDTH.
- DATA_WIDTH, 16: DAC word width, i.e. bits per frame.
- SCLK_HALF, 2: clk cycles per dac_sclk half-period; must be >= 1.
- CS_GAP, 2: minimum clk cycles dac_cs_n stays high between frames; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  IN_WIDTH  signed control word (two's complement).
- data_valid  input  1  data_in is valid this cycle.
- data_ready  output  1  block can accept a word this cycle.
- dac_sclk  output  1  serial clock to DAC; idles low; DAC samples on rising edge.
- dac_cs_n  output  1  active-low frame select.
- dac_sdi  output  1  serial data, MSB first.
- frame_done  output  1  one-cycle pulse when a frame completes.
- sat_flag  output  1  last accepted word was clipped.

Behaviour:
- Reset and outputs:
  - While reset=1, at the next edge: state=IDLE, dac_cs_n=1, dac_sclk=0, dac_sdi=0, frame_done=0, sat_flag=0, counters cleared.
  - data_ready = (state==IDLE) && !reset. It is combinational from registered state; all other outputs are registered.
  - Reset mid-frame aborts the frame cleanly: the cycle after reset is sampled, cs_n=1 and sclk=0. There is no partial-frame completion and no frame_done pulse.
- Accept:
  - A word is accepted at cycle T when data_valid && data_ready.
  - data_in is ignored whenever data_ready=0. There is no buffering and no back-pressure beyond data_ready.
- Saturation (evaluated at accept):
  - If data_in > 2^(DATA_WIDTH-1)-1, clamp to 2^(DATA_WIDTH-1)-1.
  - If data_in < -2^(DATA_WIDTH-1), clamp to -2^(DATA_WIDTH-1).
  - Otherwise truncate to the low DATA_WIDTH bits, which is exact in range.
  - sat_flag is registered at T+1 to 1 if clipped, else 0. It holds until the next accept.
- Encoding: shift register is loaded at T+1 with the clamped value, MSB inverted (offset binary): -32768 -> 0x0000, 0 -> 0x8000, 32767 -> 0xFFFF.
- FSM states are IDLE, SETUP, SHIFT, HOLD, GAP.
  - IDLE: cs_n=1, sclk=0, sdi=0. On accept go to SETUP.
  - SETUP (from T+1): cs_n=0, sclk=0, sdi=word MSB, held for SCLK_HALF cycles, then SHIFT.
  - SHIFT: for bit i = DATA_WIDTH-1 down to 0:
    - sclk=1 for SCLK_HALF cycles, then sclk=0 for SCLK_HALF cycles.
    - sdi changes only on the high-to-low sclk transition, advancing to the next bit.
    - sdi is stable for the whole high phase plus the surrounding low phases.
    - The low phase after bit 0 is the HOLD state: sdi holds bit 0, cs_n=0.
  - After HOLD: cs_n=1, sdi=0, frame_done=1 for exactly that one cycle, then GAP.
  - GAP: cs_n=1 for CS_GAP cycles total, counting the frame_done cycle, then IDLE.
- Timing (defaults):
  - cs_n low for SCLK_HALF*(1+2*DATA_WIDTH) = 66 cycles, T+1..T+66.
  - Exactly DATA_WIDTH = 16 sclk rising edges per frame.
  - frame_done at T+67; data_ready high again at T+67+CS_GAP = T+69.
  - Sustained throughput: one word per 69 clk cycles.
- Boundary rules:
  - data_valid held high continuously: the next accept occurs exactly on the first IDLE cycle.
  - data_in changes mid-frame: no effect on the frame in progress.
  - Counters must not wrap or overrun for any legal parameter combination.

Test Plan:
- Reset: hold reset 3 cycles with data_valid=1 -> cs_n=1, sclk=0, sdi=0, frame_done=0, sat_flag=0, data_ready=0 during reset, then 1 the cycle after release.
- data_in=0 accepted at T -> sdi sampled on 16 rising edges = 0x8000; cs_n low T+1..T+66; frame_done only at T+67; data_ready at T+69; sat_flag=0.
- data_in=24'hFFFFFF (-1) -> 0x7FFF shifted. data_in=-32768 -> 0x0000. data_in=32767 -> 0xFFFF. sat_flag=0 in all three cases.
- Saturation:
  - data_in=24'h012345 (+74565) -> 0xFFFF, sat_flag=1.
  - Then data_in=-40000 -> 0x0000, sat_flag=1.
  - Then data_in=100 -> 0x8064, sat_flag=0.
- data_valid held high with data_in incrementing every cycle -> accepts spaced exactly 69 cycles; each frame carries the value present at its accept cycle; no other values appear.
- Reset asserted after the 7th sclk rising edge -> next cycle cs_n=1, sclk=0, no frame_done. Next accept produces a clean 66-cycle frame.
- Rebuild with SCLK_HALF=1, CS_GAP=1 -> cs_n low 33 cycles, frame_done at T+34, data_ready at T+35, bit values correct.
